// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the pipeline control logic: forwarding mux
// select codes and the memory wait-state FSM encoding.
package core_ctrl_pkg;

  // EX-stage operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;  // register file value from ID/EX
  localparam logic [1:0] FWD_MEM = 2'b01;  // result held in EX/MEM
  localparam logic [1:0] FWD_WB  = 2'b10;  // result held in MEM/WB

  // Data-memory wait-state FSM
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/forwarding_unit.sv
// Selects the source of one EX-stage operand. The youngest producer
// (EX/MEM) takes precedence over the older one (MEM/WB); x0 is never
// forwarded because it always reads as zero.
module forwarding_unit
  import core_ctrl_pkg::*;
(
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] fwd_sel
);

  // Pick the most recent in-flight writer of ex_rs
  always_comb begin
    // NOTE: assigning a default first guarantees every path drives the output, so no latch is inferred.
    fwd_sel = FWD_RF;
    if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      fwd_sel = FWD_MEM;
    end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Central sequencer for the 5-stage pipeline. Stalls, holds and flushes
// the pipeline registers for data-memory wait states, EX-resolved
// redirects and load-use hazards; drives the EX forwarding selects;
// tracks wait-state timeouts and keeps saturating stall/flush counters.
module hazard_control_unit
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_to_reg,
  input  logic             ex_redirect,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_hold,
  output logic             id_ex_flush,
  output logic             ex_mem_hold,
  output logic             mem_wb_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             in_mem_wait,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  // Wait counter only needs to reach MEM_TIMEOUT-1
  localparam int                WCNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  state_e            state;
  state_e            state_next;
  logic [WCNT_W-1:0] wait_cnt;
  logic [WCNT_W-1:0] wait_inc;
  logic              wait_c;
  logic              load_use;
  logic              redirect_flush;

  assign wait_c   = mem_req & ~mem_ready;
  assign load_use = ex_mem_to_reg && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));
  // A redirect only takes effect once memory is no longer stalling EX
  assign redirect_flush = ~wait_c & ex_redirect;
  assign wait_inc       = wait_cnt + WCNT_W'(1);
  assign in_mem_wait    = (state == ST_WAIT);

  forwarding_unit u_fwd_a (
    .ex_rs         (ex_rs1),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_a_sel)
  );

  forwarding_unit u_fwd_b (
    .ex_rs         (ex_rs2),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .fwd_sel       (fwd_b_sel)
  );

  // Pipeline control, priority: memory wait > redirect > load-use
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_hold   = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_hold  = 1'b0;
    mem_wb_flush = 1'b0;
    if (wait_c) begin
      // Freeze everything up to EX/MEM and bubble into WB; a pending
      // redirect stays valid in the frozen EX stage.
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_hold   = 1'b1;
      ex_mem_hold  = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ex_redirect) begin
      // Wrong-path instructions in IF and ID are discarded
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (load_use) begin
      // One bubble; the load result then forwards from MEM/WB
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // Wait-state FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN:  if (wait_c) state_next = ST_WAIT;
      ST_WAIT: if (!wait_c) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // Wait-state FSM register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // Consecutive-wait counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (state == ST_RUN) begin
      wait_cnt <= '0;
    end else if (wait_c && (wait_cnt != WCNT_LAST)) begin
      wait_cnt <= wait_inc;
      if (wait_inc == WCNT_LAST) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (pc_stall && (stall_count != '1)) begin
        stall_count <= stall_count + CNT_W'(1);
      end
      if (redirect_flush && (flush_count != '1)) begin
        flush_count <= flush_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: a table of hand-derived
// vectors, directed multi-cycle sequences, and randomized traffic checked
// against a cycle-level behavioural model.
module tb_hazard_control_unit;

  localparam int CNT_W       = 4;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  // Control output pattern {pc_stall, if_id_stall, if_id_flush,
  // id_ex_hold, id_ex_flush, ex_mem_hold, mem_wb_flush}
  localparam logic [6:0] CTL_NONE = 7'b0000000;
  localparam logic [6:0] CTL_WAIT = 7'b1101011;
  localparam logic [6:0] CTL_RED  = 7'b0010100;
  localparam logic [6:0] CTL_LU   = 7'b1100100;

  typedef struct {
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic [4:0] ex_rs1, ex_rs2, ex_rd;
    logic       ex_mem_to_reg, ex_redirect;
    logic [4:0] mem_rd;
    logic       mem_reg_write, mem_req, mem_ready;
    logic [4:0] wb_rd;
    logic       wb_reg_write;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] ctl;
    logic [1:0] fa, fb;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [4:0]       id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0;
  logic [4:0]       ex_rd = '0, mem_rd = '0, wb_rd = '0;
  logic             id_use_rs1 = 0, id_use_rs2 = 0, ex_mem_to_reg = 0, ex_redirect = 0;
  logic             mem_reg_write = 0, mem_req = 0, mem_ready = 0, wb_reg_write = 0;
  logic             pc_stall, if_id_stall, if_id_flush, id_ex_hold, id_ex_flush;
  logic             ex_mem_hold, mem_wb_flush, in_mem_wait, mem_timeout;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0] stall_count, flush_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int   m_stall   = 0;
  int   m_flush   = 0;
  int   m_streak  = 0;
  logic m_in_wait = 1'b0;
  logic m_timeout = 1'b0;

  always #5 clk = ~clk;

  hazard_control_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_use_rs1    (id_use_rs1),
    .id_use_rs2    (id_use_rs2),
    .ex_rs1        (ex_rs1),
    .ex_rs2        (ex_rs2),
    .ex_rd         (ex_rd),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_redirect   (ex_redirect),
    .mem_rd        (mem_rd),
    .mem_reg_write (mem_reg_write),
    .mem_req       (mem_req),
    .mem_ready     (mem_ready),
    .wb_rd         (wb_rd),
    .wb_reg_write  (wb_reg_write),
    .pc_stall      (pc_stall),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .id_ex_hold    (id_ex_hold),
    .id_ex_flush   (id_ex_flush),
    .ex_mem_hold   (ex_mem_hold),
    .mem_wb_flush  (mem_wb_flush),
    .fwd_a_sel     (fwd_a_sel),
    .fwd_b_sel     (fwd_b_sel),
    .in_mem_wait   (in_mem_wait),
    .mem_timeout   (mem_timeout),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic in_t zero_in();
    in_t v;
    v.id_rs1 = '0; v.id_rs2 = '0; v.id_use_rs1 = 0; v.id_use_rs2 = 0;
    v.ex_rs1 = '0; v.ex_rs2 = '0; v.ex_rd = '0;
    v.ex_mem_to_reg = 0; v.ex_redirect = 0;
    v.mem_rd = '0; v.mem_reg_write = 0; v.mem_req = 0; v.mem_ready = 0;
    v.wb_rd = '0; v.wb_reg_write = 0;
    return v;
  endfunction

  function automatic in_t rand_in();
    in_t v;
    v.id_rs1        = 5'($urandom_range(0, 3));
    v.id_rs2        = 5'($urandom_range(0, 3));
    v.id_use_rs1    = 1'($urandom_range(0, 1));
    v.id_use_rs2    = 1'($urandom_range(0, 1));
    v.ex_rs1        = 5'($urandom_range(0, 3));
    v.ex_rs2        = 5'($urandom_range(0, 3));
    v.ex_rd         = 5'($urandom_range(0, 3));
    v.ex_mem_to_reg = 1'($urandom_range(0, 1));
    v.ex_redirect   = ($urandom_range(0, 4) == 0);
    v.mem_rd        = 5'($urandom_range(0, 3));
    v.mem_reg_write = 1'($urandom_range(0, 1));
    v.mem_req       = ($urandom_range(0, 9) < 6);
    v.mem_ready     = ($urandom_range(0, 3) == 0);
    v.wb_rd         = 5'($urandom_range(0, 3));
    v.wb_reg_write  = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Expected control pattern straight from the priority rules
  function automatic logic [6:0] model_ctl(input in_t v);
    logic hit1, hit2;
    hit1 = v.id_use_rs1 && (v.id_rs1 == v.ex_rd);
    hit2 = v.id_use_rs2 && (v.id_rs2 == v.ex_rd);
    if (v.mem_req && !v.mem_ready) return CTL_WAIT;
    if (v.ex_redirect) return CTL_RED;
    if (v.ex_mem_to_reg && v.ex_rd != 0 && (hit1 || hit2)) return CTL_LU;
    return CTL_NONE;
  endfunction

  function automatic logic [1:0] model_fwd(input logic [4:0] rs, input in_t v);
    if (v.mem_reg_write && v.mem_rd != 0 && v.mem_rd == rs) return 2'b01;
    if (v.wb_reg_write && v.wb_rd != 0 && v.wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  task automatic apply(input in_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2;
    id_use_rs1 = v.id_use_rs1; id_use_rs2 = v.id_use_rs2;
    ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
    ex_mem_to_reg = v.ex_mem_to_reg; ex_redirect = v.ex_redirect;
    mem_rd = v.mem_rd; mem_reg_write = v.mem_reg_write;
    mem_req = v.mem_req; mem_ready = v.mem_ready;
    wb_rd = v.wb_rd; wb_reg_write = v.wb_reg_write;
  endtask

  // One clock: drive, check all outputs against the model mid-cycle,
  // then advance the model across the rising edge.
  task automatic run_cycle(input in_t v);
    logic [6:0] ctl;
    logic       w;
    apply(v);
    ctl = model_ctl(v);
    @(negedge clk);
    check("ctl", {pc_stall, if_id_stall, if_id_flush, id_ex_hold,
                  id_ex_flush, ex_mem_hold, mem_wb_flush}, 32'(ctl));
    check("fwd_a_sel", fwd_a_sel, model_fwd(v.ex_rs1, v));
    check("fwd_b_sel", fwd_b_sel, model_fwd(v.ex_rs2, v));
    check("in_mem_wait", in_mem_wait, m_in_wait);
    check("mem_timeout", mem_timeout, m_timeout);
    check("stall_count", stall_count, 32'(m_stall));
    check("flush_count", flush_count, 32'(m_flush));
    @(posedge clk);
    w = v.mem_req && !v.mem_ready;
    if (rst) begin
      m_stall = 0; m_flush = 0; m_streak = 0;
      m_in_wait = 0; m_timeout = 0;
    end else begin
      if (ctl[6] && m_stall < CNT_MAX) m_stall++;
      if (!w && v.ex_redirect && m_flush < CNT_MAX) m_flush++;
      m_streak  = w ? m_streak + 1 : 0;
      if (m_streak >= MEM_TIMEOUT) m_timeout = 1'b1;
      m_in_wait = w;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run_cycle(zero_in());
    rst = 1'b0;
  endtask

  initial begin
    vec_t vecs[13];
    in_t  v;

    // Hand-derived vectors, applied back to back from reset
    v = zero_in();
    vecs[0] = '{in: v, ctl: CTL_NONE, fa: 2'b00, fb: 2'b00};
    v.ex_mem_to_reg = 1; v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 1;
    vecs[1] = '{in: v, ctl: CTL_LU, fa: 2'b00, fb: 2'b00};
    v.ex_rd = 0; v.id_rs1 = 0;
    vecs[2] = '{in: v, ctl: CTL_NONE, fa: 2'b00, fb: 2'b00};
    v.ex_rd = 5; v.id_rs1 = 5; v.id_use_rs1 = 0;
    vecs[3] = '{in: v, ctl: CTL_NONE, fa: 2'b00, fb: 2'b00};
    v.ex_rd = 9; v.id_rs2 = 9; v.id_use_rs2 = 1;
    vecs[4] = '{in: v, ctl: CTL_LU, fa: 2'b00, fb: 2'b00};
    v.ex_redirect = 1;
    vecs[5] = '{in: v, ctl: CTL_RED, fa: 2'b00, fb: 2'b00};
    v = zero_in();
    v.ex_rs1 = 7; v.mem_rd = 7; v.wb_rd = 7; v.mem_reg_write = 1; v.wb_reg_write = 1;
    vecs[6] = '{in: v, ctl: CTL_NONE, fa: 2'b01, fb: 2'b00};
    v.mem_reg_write = 0;
    vecs[7] = '{in: v, ctl: CTL_NONE, fa: 2'b10, fb: 2'b00};
    v.mem_reg_write = 1; v.mem_rd = 0; v.wb_rd = 0;
    vecs[8] = '{in: v, ctl: CTL_NONE, fa: 2'b00, fb: 2'b00};
    v.ex_rs1 = 0;
    vecs[9] = '{in: v, ctl: CTL_NONE, fa: 2'b00, fb: 2'b00};
    v = zero_in();
    v.ex_rs2 = 3; v.mem_rd = 3; v.wb_rd = 3; v.wb_reg_write = 1;
    v.ex_rs1 = 3; v.mem_req = 1; v.ex_redirect = 1;
    vecs[10] = '{in: v, ctl: CTL_WAIT, fa: 2'b10, fb: 2'b10};
    v.mem_ready = 1;
    vecs[11] = '{in: v, ctl: CTL_RED, fa: 2'b10, fb: 2'b10};
    v = zero_in();
    v.ex_mem_to_reg = 1; v.ex_rd = 2; v.id_rs2 = 2; v.id_use_rs2 = 1;
    v.mem_ready = 1;
    vecs[12] = '{in: v, ctl: CTL_LU, fa: 2'b00, fb: 2'b00};

    do_reset();
    check("reset stall_count", stall_count, 0);
    check("reset flush_count", flush_count, 0);
    check("reset in_mem_wait", in_mem_wait, 0);
    check("reset mem_timeout", mem_timeout, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].in);
      #1;
      check($sformatf("vec%0d ctl", i),
            {pc_stall, if_id_stall, if_id_flush, id_ex_hold,
             id_ex_flush, ex_mem_hold, mem_wb_flush}, 32'(vecs[i].ctl));
      check($sformatf("vec%0d fwd_a", i), fwd_a_sel, vecs[i].fa);
      check($sformatf("vec%0d fwd_b", i), fwd_b_sel, vecs[i].fb);
      run_cycle(vecs[i].in);
    end

    // Single load-use: one bubble, counted as a stall only
    do_reset();
    run_cycle(vecs[1].in);
    run_cycle(zero_in());
    check("lu stall_count", stall_count, 1);
    check("lu flush_count", flush_count, 0);

    // Redirect together with load-use: one counted flush, no stall
    do_reset();
    run_cycle(vecs[5].in);
    check("red+lu stall_count", stall_count, 0);
    check("red+lu flush_count", flush_count, 1);

    // Three wait cycles with a pending redirect, then release
    do_reset();
    v = zero_in();
    v.mem_req = 1; v.ex_redirect = 1;
    for (int c = 1; c <= 3; c++) begin
      apply(v);
      #1;
      check($sformatf("wait%0d mem_wb_flush", c), mem_wb_flush, 1);
      check($sformatf("wait%0d flushes", c), {if_id_flush, id_ex_flush}, 0);
      check($sformatf("wait%0d in_mem_wait", c), in_mem_wait, (c >= 2));
      run_cycle(v);
    end
    v.mem_ready = 1;
    apply(v);
    #1;
    check("release flushes", {if_id_flush, id_ex_flush, pc_stall}, 3'b110);
    check("release in_mem_wait", in_mem_wait, 1);
    run_cycle(v);
    check("release stall_count", stall_count, 3);
    check("release flush_count", flush_count, 1);

    // Timeout after MEM_TIMEOUT consecutive wait cycles, sticky afterwards
    do_reset();
    v = zero_in();
    v.mem_req = 1;
    for (int c = 1; c <= 6; c++) begin
      run_cycle(v);
      check($sformatf("timeout after wait%0d", c), mem_timeout, (c >= 4));
    end
    run_cycle(zero_in());
    run_cycle(zero_in());
    check("timeout sticky", mem_timeout, 1);

    // Reset in the middle of a wait
    run_cycle(v);
    run_cycle(v);
    rst = 1'b1;
    run_cycle(v);
    rst = 1'b0;
    check("rst mid-wait in_mem_wait", in_mem_wait, 0);
    check("rst mid-wait mem_timeout", mem_timeout, 0);
    check("rst mid-wait stall_count", stall_count, 0);

    // Counter saturation
    for (int c = 0; c < CNT_MAX + 5; c++) run_cycle(vecs[1].in);
    check("stall_count saturates", stall_count, CNT_MAX);

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      run_cycle(rand_in());
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
